score_judge: RTL and testbench

SCORE_JUDGE -- requirements
Module: score_judge

---
 rtl/game_pkg.sv | 27 ++
 rtl/score_counter.sv | 32 +++
 rtl/score_judge.sv | 125 ++++++++++++
 tb/tb_score_judge.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared answer width, win score, winner codes and judge state encodings
package game_pkg;

  localparam int ANS_W     = 8;
  localparam int WIN_SCORE = 5;

  localparam logic [3:0] SCORE_MAX = 4'd15;

  localparam logic [1:0] WINNER_NONE = 2'd0;
  localparam logic [1:0] WINNER_P1   = 2'd1;
  localparam logic [1:0] WINNER_P2   = 2'd2;
  localparam logic [1:0] WINNER_TIE  = 2'd3;

  localparam logic [1:0] JS_READY  = 2'd0;
  localparam logic [1:0] JS_LOCKED = 2'd1;
  localparam logic [1:0] JS_OVER   = 2'd2;

  // One saturating step of a 4-bit score; inc and dec together cancel out.
  function automatic logic [3:0] sat_step(input logic [3:0] v, input logic inc, input logic dec);
    logic [3:0] r;
    r = v;
    if (inc && !dec && v != SCORE_MAX) r = v + 4'd1;
    if (dec && !inc && v != 4'd0)      r = v - 4'd1;
    return r;
  endfunction

endpackage

// File: rtl/score_counter.sv
// rtl/score_counter.sv - 4-bit saturating up/down score counter with synchronous clear
module score_counter (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       clr_i,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [3:0] count_o,
  output logic [3:0] count_d_o
);
  import game_pkg::*;

  logic [3:0] count_q;
  logic [3:0] count_d;

  // Next count: clear beats any step; the step never wraps past 0 or 15.
  always_comb begin
    count_d = count_q;
    if (clr_i) count_d = 4'd0;
    else       count_d = sat_step(count_q, inc_i, dec_i);
  end

  // Count register with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) count_q <= 4'd0;
    else         count_q <= count_d;
  end

  assign count_o   = count_q;
  assign count_d_o = count_d;

endmodule

// File: rtl/score_judge.sv
// rtl/score_judge.sv - judges player submissions, keeps scores and detects the winner
module score_judge #(
  parameter int ANS_W     = game_pkg::ANS_W,
  parameter int WIN_SCORE = game_pkg::WIN_SCORE
) (
  input  logic             clk_100mhz,
  input  logic             reset,
  input  logic             state_idle,
  input  logic             state_wait,
  input  logic             new_question,
  input  logic             p1_submit_event,
  input  logic             p2_submit_event,
  input  logic [ANS_W-1:0] p1_answer,
  input  logic [ANS_W-1:0] p2_answer,
  input  logic [ANS_W-1:0] expected_answer,
  output logic             is_ans_correct,
  output logic             is_game_over,
  output logic [3:0]       p1_score,
  output logic [3:0]       p2_score,
  output logic [1:0]       winner,
  output logic [1:0]       last_submitter
);
  import game_pkg::*;

  localparam logic [3:0] WIN4 = 4'(WIN_SCORE);

  logic [1:0] state_q, state_d;
  logic       is_ans_correct_q, is_ans_correct_d;
  logic       is_game_over_q, is_game_over_d;
  logic [1:0] winner_q, winner_d;
  logic [1:0] last_submitter_q, last_submitter_d;

  logic       judge;
  logic       p1_ok, p2_ok;
  logic       p1_reach, p2_reach;
  logic [3:0] p1_next, p2_next;

  // A judge cycle needs READY, WAIT and at least one submit; idle clearing always wins.
  always_comb begin
    judge = (state_q == JS_READY) && state_wait && !state_idle
            && (p1_submit_event || p2_submit_event);
    p1_ok = (p1_answer == expected_answer);
    p2_ok = (p2_answer == expected_answer);
  end

  score_counter u_p1_score (
    .clk_i     (clk_100mhz),
    .reset_i   (reset),
    .clr_i     (state_idle),
    .inc_i     (judge && p1_submit_event && p1_ok),
    .dec_i     (judge && p1_submit_event && !p1_ok),
    .count_o   (p1_score),
    .count_d_o (p1_next)
  );

  score_counter u_p2_score (
    .clk_i     (clk_100mhz),
    .reset_i   (reset),
    .clr_i     (state_idle),
    .inc_i     (judge && p2_submit_event && p2_ok),
    .dec_i     (judge && p2_submit_event && !p2_ok),
    .count_o   (p2_score),
    .count_d_o (p2_next)
  );

  // Judge FSM: winner code bits line up with which player reached the win score.
  always_comb begin
    state_d          = state_q;
    is_ans_correct_d = is_ans_correct_q;
    is_game_over_d   = is_game_over_q;
    winner_d         = winner_q;
    last_submitter_d = last_submitter_q;
    p1_reach         = (p1_next >= WIN4);
    p2_reach         = (p2_next >= WIN4);
    if (state_idle) begin
      state_d          = JS_READY;
      is_ans_correct_d = 1'b0;
      is_game_over_d   = 1'b0;
      winner_d         = WINNER_NONE;
      last_submitter_d = 2'b00;
    end else begin
      case (state_q)
        JS_READY: begin
          if (judge) begin
            is_ans_correct_d = (p1_submit_event && p1_ok) || (p2_submit_event && p2_ok);
            last_submitter_d = {p2_submit_event, p1_submit_event};
            if (p1_reach || p2_reach) begin
              is_game_over_d = 1'b1;
              winner_d       = {p2_reach, p1_reach};
              state_d        = JS_OVER;
            end else begin
              state_d = JS_LOCKED;
            end
          end
        end
        JS_LOCKED: if (new_question) state_d = JS_READY;
        JS_OVER:   state_d = JS_OVER;
        default:   state_d = JS_READY;
      endcase
    end
  end

  // Registered judge state and flags; reset overrides every other input.
  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      state_q          <= JS_READY;
      is_ans_correct_q <= 1'b0;
      is_game_over_q   <= 1'b0;
      winner_q         <= WINNER_NONE;
      last_submitter_q <= 2'b00;
    end else begin
      state_q          <= state_d;
      is_ans_correct_q <= is_ans_correct_d;
      is_game_over_q   <= is_game_over_d;
      winner_q         <= winner_d;
      last_submitter_q <= last_submitter_d;
    end
  end

  assign is_ans_correct = is_ans_correct_q;
  assign is_game_over   = is_game_over_q;
  assign winner         = winner_q;
  assign last_submitter = last_submitter_q;

endmodule

// File: tb/tb_score_judge.sv
// tb/tb_score_judge.sv - self-checking bench for score_judge with a behavioural game model
module tb_score_judge;
  import game_pkg::*;

  logic       clk_100mhz = 1'b0;
  logic       reset, state_idle, state_wait, new_question;
  logic       p1_submit_event, p2_submit_event, b_p1_submit;
  logic [7:0] p1_answer, p2_answer, expected_answer;

  logic       a_ac, a_go, b_ac, b_go;
  logic [3:0] a_p1, a_p2, b_p1, b_p2;
  logic [1:0] a_win, a_ls, b_win, b_ls;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  // model of the default-parameter instance
  int m_s1, m_s2, m_ac, m_go, m_win, m_ls, m_st;
  localparam int M_READY = 0, M_LOCKED = 1, M_OVER = 2;
  localparam int M_WIN = 5;

  always #5 clk_100mhz = ~clk_100mhz;

  score_judge dut_a (
    .clk_100mhz(clk_100mhz), .reset(reset), .state_idle(state_idle), .state_wait(state_wait),
    .new_question(new_question), .p1_submit_event(p1_submit_event),
    .p2_submit_event(p2_submit_event), .p1_answer(p1_answer), .p2_answer(p2_answer),
    .expected_answer(expected_answer), .is_ans_correct(a_ac), .is_game_over(a_go),
    .p1_score(a_p1), .p2_score(a_p2), .winner(a_win), .last_submitter(a_ls)
  );

  score_judge #(.WIN_SCORE(15)) dut_b (
    .clk_100mhz(clk_100mhz), .reset(reset), .state_idle(state_idle), .state_wait(state_wait),
    .new_question(new_question), .p1_submit_event(b_p1_submit),
    .p2_submit_event(p2_submit_event), .p1_answer(p1_answer), .p2_answer(p2_answer),
    .expected_answer(expected_answer), .is_ans_correct(b_ac), .is_game_over(b_go),
    .p1_score(b_p1), .p2_score(b_p2), .winner(b_win), .last_submitter(b_ls)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int model_state_code(input int st);
    if (st == M_LOCKED) return int'(JS_LOCKED);
    if (st == M_OVER)   return int'(JS_OVER);
    return int'(JS_READY);
  endfunction

  // game rules applied to plain integers at each clock edge
  always @(posedge clk_100mhz) begin
    if (reset || state_idle) begin
      m_s1 = 0; m_s2 = 0; m_ac = 0; m_go = 0; m_win = 0; m_ls = 0; m_st = M_READY;
    end else if (m_st == M_READY) begin
      if (state_wait && (p1_submit_event || p2_submit_event)) begin
        m_ac = 0;
        if (p1_submit_event) begin
          if (p1_answer == expected_answer) begin m_s1 = (m_s1 < 15) ? m_s1 + 1 : 15; m_ac = 1; end
          else m_s1 = (m_s1 > 0) ? m_s1 - 1 : 0;
        end
        if (p2_submit_event) begin
          if (p2_answer == expected_answer) begin m_s2 = (m_s2 < 15) ? m_s2 + 1 : 15; m_ac = 1; end
          else m_s2 = (m_s2 > 0) ? m_s2 - 1 : 0;
        end
        m_ls = (p1_submit_event ? 1 : 0) + (p2_submit_event ? 2 : 0);
        if (m_s1 >= M_WIN || m_s2 >= M_WIN) begin
          m_go = 1;
          m_win = (m_s1 >= M_WIN ? 1 : 0) + (m_s2 >= M_WIN ? 2 : 0);
          m_st = M_OVER;
        end else begin
          m_st = M_LOCKED;
        end
      end
    end else if (m_st == M_LOCKED) begin
      if (new_question) m_st = M_READY;
    end
  end

  // every-cycle comparison of instance A against the model
  always @(negedge clk_100mhz) begin
    if (check_en) begin
      check("p1_score", a_p1, m_s1);
      check("p2_score", a_p2, m_s2);
      check("is_ans_correct", a_ac, m_ac);
      check("is_game_over", a_go, m_go);
      check("winner", a_win, m_win);
      check("last_submitter", a_ls, m_ls);
      check("fsm_state", dut_a.state_q, model_state_code(m_st));
    end
  end

  task automatic tick();
    @(posedge clk_100mhz);
    #2;
  endtask

  task automatic apply(input bit s1, input logic [7:0] a1, input bit s2, input logic [7:0] a2,
                       input bit nq, input bit idle, input bit rst);
    p1_submit_event = s1; p1_answer = a1;
    p2_submit_event = s2; p2_answer = a2;
    new_question = nq; state_idle = idle; reset = rst;
    tick();
    p1_submit_event = 1'b0; p2_submit_event = 1'b0;
    new_question = 1'b0; state_idle = 1'b0; reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; state_idle = 1'b0; state_wait = 1'b0; new_question = 1'b0;
    p1_submit_event = 1'b0; p2_submit_event = 1'b0; b_p1_submit = 1'b0;
    p1_answer = 8'd0; p2_answer = 8'd0; expected_answer = 8'd12;
    tick(); tick();
    reset = 1'b0;
    check("reset_p1", a_p1, 0);
    check("reset_go", a_go, 0);
    check("reset_winner", a_win, 0);
    check("reset_ls", a_ls, 0);
    check_en = 1'b1;

    state_wait = 1'b1;
    apply(1, 8'd12, 0, 8'd0, 0, 0, 0);
    check("first_p1", a_p1, 1);
    check("first_ac", a_ac, 1);
    check("first_ls", a_ls, 2'b01);
    check("first_locked", dut_a.state_q, JS_LOCKED);

    apply(0, 8'd0, 1, 8'd12, 0, 0, 0);
    check("locked_ignore_p2", a_p2, 0);
    apply(0, 8'd0, 0, 8'd0, 1, 0, 0);
    apply(0, 8'd0, 1, 8'd3, 0, 0, 0);
    check("p2_sat_zero", a_p2, 0);
    check("p2_wrong_ac", a_ac, 0);

    apply(1, 8'd12, 0, 8'd0, 1, 0, 0);
    check("nq_submit_p1", a_p1, 1);
    check("nq_submit_ready", dut_a.state_q, JS_READY);

    state_wait = 1'b0;
    apply(1, 8'd12, 0, 8'd0, 0, 0, 0);
    check("nowait_p1", a_p1, 1);
    state_wait = 1'b1;

    apply(1, 8'd140, 0, 8'd0, 0, 0, 0);
    check("msb_diff_wrong", a_p1, 0);
    apply(0, 8'd0, 0, 8'd0, 1, 0, 0);

    for (int i = 0; i < 4; i++) begin
      apply(1, 8'd12, 1, 8'd12, 0, 0, 0);
      apply(0, 8'd0, 0, 8'd0, 1, 0, 0);
    end
    check("pre_tie_p1", a_p1, 4);
    check("pre_tie_go", a_go, 0);
    apply(1, 8'd12, 1, 8'd12, 0, 0, 0);
    check("tie_p1", a_p1, 5);
    check("tie_p2", a_p2, 5);
    check("tie_go", a_go, 1);
    check("tie_winner", a_win, 3);
    for (int i = 0; i < 3; i++) apply(1, 8'd0, 1, 8'd12, 1, 0, 0);
    check("over_hold_p1", a_p1, 5);
    check("over_hold_winner", a_win, 3);
    apply(0, 8'd0, 0, 8'd0, 0, 1, 0);
    check("idle_clear_p1", a_p1, 0);
    check("idle_clear_go", a_go, 0);

    for (int i = 0; i < 4; i++) begin
      apply(1, 8'd7, 1, 8'd12, 0, 0, 0);
      apply(0, 8'd0, 0, 8'd0, 1, 0, 0);
    end
    apply(0, 8'd0, 1, 8'd12, 0, 0, 0);
    check("p2_win_go", a_go, 1);
    check("p2_win_winner", a_win, 2);
    apply(0, 8'd0, 0, 8'd0, 0, 1, 0);
    check("p2_idle_p2", a_p2, 0);
    check("p2_idle_winner", a_win, 0);
    check("p2_idle_ready", dut_a.state_q, JS_READY);

    apply(1, 8'd12, 0, 8'd0, 0, 1, 0);
    check("idle_beats_submit", a_p1, 0);

    apply(1, 8'd12, 0, 8'd0, 0, 0, 0);
    apply(0, 8'd0, 0, 8'd0, 1, 0, 0);
    apply(1, 8'd12, 0, 8'd0, 0, 0, 1);
    check("reset_beats_submit", a_p1, 0);
    check("reset_beats_ac", a_ac, 0);

    for (int k = 1; k <= 15; k++) begin
      p1_answer = 8'd12; b_p1_submit = 1'b1;
      tick();
      b_p1_submit = 1'b0;
      if (k == 14) begin
        check("b_p1_14", b_p1, 14);
        check("b_go_14", b_go, 0);
      end
      apply(0, 8'd12, 0, 8'd0, 1, 0, 0);
    end
    check("b_p1_15", b_p1, 15);
    check("b_go_15", b_go, 1);
    check("b_winner_15", b_win, 1);
    b_p1_submit = 1'b1;
    tick();
    b_p1_submit = 1'b0;
    check("b_no_wrap", b_p1, 15);

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
